wb_arbiter: RTL and testbench

//  Write-back stage directly upstream of the register file: drives its single

---
 rtl/wb_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the register-file write port: merges never-stalled ALU results with
// load returns buffered in a small FIFO, and reports pending writes for RAW hazard stalls.
module wb_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DEPTH   = 4,
  parameter bit          DROP_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              stall_req,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              pend1,
  output logic              pend2,
  output logic              we3,
  output logic [ADDR_W-1:0] addr3,
  output logic [DATA_W-1:0] writeData3
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_we3;
  logic [ADDR_W-1:0] r_addr3;
  logic [DATA_W-1:0] r_data3;

  logic w_full;
  logic w_empty;
  logic w_mem_r0;
  logic w_alu_r0;
  logic w_push;
  logic w_pop;
  logic w_alu_sel;
  logic w_pend1;
  logic w_pend2;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_mem_r0  = DROP_R0 && (mem_addr == '0);
  assign w_alu_r0  = DROP_R0 && (alu_addr == '0);
  // An r0 load still handshakes; it is simply never stored.
  assign w_push    = mem_valid && !w_full && !w_mem_r0;
  assign w_alu_sel = alu_valid && !w_alu_r0;
  assign w_pop     = !w_alu_sel && !w_empty;

  assign mem_ready  = !w_full;
  assign stall_req  = (r_count >= CNT_W'(DEPTH - 1));
  assign we3        = r_we3;
  assign addr3      = r_addr3;
  assign writeData3 = r_data3;
  assign pend1      = w_pend1;
  assign pend2      = w_pend2;

  always_comb begin
    w_pend1 = r_we3 && (r_addr3 == rs1);
    w_pend2 = r_we3 && (r_addr3 == rs2);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_vld[i] && (r_addr_mem[i] == rs1)) w_pend1 = 1'b1;
      if (r_vld[i] && (r_addr_mem[i] == rs2)) w_pend2 = 1'b1;
    end
    if (DROP_R0 && (rs1 == '0)) w_pend1 = 1'b0;
    if (DROP_R0 && (rs2 == '0)) w_pend2 = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_wr_ptr] <= mem_addr;
      r_data_mem[r_wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_we3    <= 1'b0;
      r_addr3  <= '0;
      r_data3  <= '0;
    end else begin
      if (w_push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // Strict priority: ALU first, then FIFO head; otherwise hold address/data.
      if (w_alu_sel) begin
        r_we3   <= 1'b1;
        r_addr3 <= alu_addr;
        r_data3 <= alu_data;
      end else if (w_pop) begin
        r_we3   <= 1'b1;
        r_addr3 <= r_addr_mem[r_rd_ptr];
        r_data3 <= r_data_mem[r_rd_ptr];
      end else begin
        r_we3 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: ALU/load paths, contention, full FIFO,
// r0 dropping and asynchronous reset with buffered loads.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [5:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [5:0]  mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        stall_req;
  logic [5:0]  rs1 = '0;
  logic [5:0]  rs2 = '0;
  logic        pend1;
  logic        pend2;
  logic        we3;
  logic [5:0]  addr3;
  logic [31:0] writeData3;

  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter #(
    .DATA_W (32),
    .ADDR_W (6),
    .DEPTH  (4),
    .DROP_R0(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .stall_req (stall_req),
    .rs1       (rs1),
    .rs2       (rs2),
    .pend1     (pend1),
    .pend2     (pend2),
    .we3       (we3),
    .addr3     (addr3),
    .writeData3(writeData3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (we3 !== 1'b0) begin
      n_err++; $display("FAIL reset_we3 got=%0b exp=0", we3); end
    n_cmp++; if (addr3 !== 6'd0) begin
      n_err++; $display("FAIL reset_addr3 got=%0d exp=0", addr3); end
    n_cmp++; if (writeData3 !== 32'd0) begin
      n_err++; $display("FAIL reset_data3 got=%0h exp=0", writeData3); end
    n_cmp++; if (mem_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready got=%0b exp=1", mem_ready); end
    n_cmp++; if (stall_req !== 1'b0) begin
      n_err++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
    n_cmp++; if (pend1 !== 1'b0 || pend2 !== 1'b0) begin
      n_err++; $display("FAIL reset_pend got=%0b%0b exp=00", pend1, pend2); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_addr = 6'd5; alu_data = 32'hDEAD_BEEF; rs1 = 6'd5;
    tick();
    alu_valid = 1'b0;
    n_cmp++; if (we3 !== 1'b1 || addr3 !== 6'd5 || writeData3 !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL alu_write got=%0b/%0d/%0h exp=1/5/deadbeef", we3, addr3, writeData3);
    end
    n_cmp++; if (pend1 !== 1'b1) begin
      n_err++; $display("FAIL alu_pend got=%0b exp=1", pend1); end
    tick();
    n_cmp++; if (we3 !== 1'b0 || addr3 !== 6'd5) begin
      n_err++; $display("FAIL alu_idle got=%0b/%0d exp=0/5", we3, addr3); end
  endtask

  task automatic test_load();
    mem_valid = 1'b1; mem_addr = 6'd7; mem_data = 32'h1234; rs1 = 6'd7;
    #1;
    n_cmp++; if (mem_ready !== 1'b1 || pend1 !== 1'b0) begin
      n_err++; $display("FAIL load_pre got=%0b/%0b exp=1/0", mem_ready, pend1); end
    tick();
    mem_valid = 1'b0;
    #1;
    n_cmp++; if (pend1 !== 1'b1 || we3 !== 1'b0) begin
      n_err++; $display("FAIL load_t1 got=%0b/%0b exp=1/0", pend1, we3); end
    tick();
    n_cmp++; if (we3 !== 1'b1 || addr3 !== 6'd7 || writeData3 !== 32'h1234 || pend1 !== 1'b1) begin
      n_err++; $display("FAIL load_t2 got=%0b/%0d/%0h/%0b exp=1/7/1234/1",
                        we3, addr3, writeData3, pend1);
    end
    tick();
    n_cmp++; if (we3 !== 1'b0 || pend1 !== 1'b0) begin
      n_err++; $display("FAIL load_t3 got=%0b/%0b exp=0/0", we3, pend1); end
  endtask

  // 6 ALU cycles (r10..r15) against 5 loads (r20..r24); writes expected in that order.
  task automatic test_contention();
    logic [5:0]  exp_a [11];
    logic [31:0] exp_d [11];
    logic        exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        exp_stl [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int li = 0;
    int wn = 0;
    for (int k = 0; k < 6; k++) begin
      exp_a[k] = 6'(10 + k); exp_d[k] = 32'hA000_0000 + 32'(k);
    end
    for (int j = 0; j < 5; j++) begin
      exp_a[6+j] = 6'(20 + j); exp_d[6+j] = 32'hB000_0000 + 32'(j);
    end
    for (int c = 0; c < 20; c++) begin
      if (we3) begin
        n_cmp++;
        if (wn >= 11 || addr3 !== exp_a[wn] || writeData3 !== exp_d[wn]) begin
          n_err++; $display("FAIL cont_write%0d got=%0d/%0h", wn, addr3, writeData3);
        end
        wn++;
      end
      alu_valid = (c < 6); alu_addr = 6'(10 + c); alu_data = 32'hA000_0000 + 32'(c);
      mem_valid = (li < 5); mem_addr = 6'(20 + li); mem_data = 32'hB000_0000 + 32'(li);
      #1;
      if (c < 6) begin
        n_cmp++; if (mem_ready !== exp_rdy[c] || stall_req !== exp_stl[c]) begin
          n_err++; $display("FAIL cont_flow c=%0d got=%0b/%0b exp=%0b/%0b",
                            c, mem_ready, stall_req, exp_rdy[c], exp_stl[c]);
        end
      end
      if (mem_valid && mem_ready) li++;
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    n_cmp++; if (wn != 11) begin
      n_err++; $display("FAIL cont_count got=%0d exp=11", wn); end
  endtask

  // Fill with 4 loads under ALU traffic, then ALU idles with loads still offered.
  task automatic test_full_pop();
    logic [5:0] exp_a [11];
    logic       exp_rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int li = 0;
    int wn = 0;
    for (int k = 0; k < 4; k++) exp_a[k] = 6'(40 + k);
    for (int j = 0; j < 7; j++) exp_a[4+j] = 6'(30 + j);
    for (int c = 0; c < 16; c++) begin
      if (we3) begin
        n_cmp++;
        if (wn >= 11 || addr3 !== exp_a[wn] || writeData3[5:0] !== exp_a[wn]) begin
          n_err++; $display("FAIL full_write%0d got=%0d/%0h", wn, addr3, writeData3);
        end
        wn++;
      end
      alu_valid = (c < 4); alu_addr = 6'(40 + c); alu_data = 32'hC000_0000 + 32'(40 + c);
      mem_valid = (li < 7); mem_addr = 6'(30 + li); mem_data = 32'hD000_0000 + 32'(30 + li);
      #1;
      if (c < 8) begin
        n_cmp++; if (mem_ready !== exp_rdy[c]) begin
          n_err++; $display("FAIL full_ready c=%0d got=%0b exp=%0b", c, mem_ready, exp_rdy[c]);
        end
      end
      if (mem_valid && mem_ready) li++;
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    n_cmp++; if (wn != 11) begin
      n_err++; $display("FAIL full_count got=%0d exp=11", wn); end
  endtask

  task automatic test_r0();
    alu_valid = 1'b1; alu_addr = 6'd0; alu_data = 32'hFFFF_FFFF;
    mem_valid = 1'b1; mem_addr = 6'd0; mem_data = 32'h5555_5555;
    rs1 = 6'd0; rs2 = 6'd0;
    #1;
    n_cmp++; if (mem_ready !== 1'b1 || pend1 !== 1'b0) begin
      n_err++; $display("FAIL r0_entry got=%0b/%0b exp=1/0", mem_ready, pend1); end
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (we3 !== 1'b0 || pend1 !== 1'b0 || stall_req !== 1'b0) begin
        n_err++; $display("FAIL r0_idle c=%0d got=%0b/%0b/%0b exp=0/0/0",
                          c, we3, pend1, stall_req);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1'b1; alu_addr = 6'(50 + c); alu_data = 32'(50 + c);
      mem_valid = 1'b1; mem_addr = 6'(60 + c); mem_data = 32'(60 + c);
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b0; rs1 = 6'd60; rs2 = 6'd52;
    #1;
    n_cmp++; if (we3 !== 1'b1 || pend1 !== 1'b1 || pend2 !== 1'b1 || stall_req !== 1'b1) begin
      n_err++; $display("FAIL rst_pre got=%0b/%0b/%0b/%0b exp=1/1/1/1",
                        we3, pend1, pend2, stall_req);
    end
    reset = 1'b1;
    #1;
    n_cmp++; if (we3 !== 1'b0 || mem_ready !== 1'b1 || stall_req !== 1'b0) begin
      n_err++; $display("FAIL rst_now got=%0b/%0b/%0b exp=0/1/0", we3, mem_ready, stall_req);
    end
    n_cmp++; if (pend1 !== 1'b0 || pend2 !== 1'b0 || addr3 !== 6'd0) begin
      n_err++; $display("FAIL rst_pend got=%0b/%0b/%0d exp=0/0/0", pend1, pend2, addr3);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (we3 !== 1'b0 || pend1 !== 1'b0) begin
        n_err++; $display("FAIL rst_after c=%0d got=%0b/%0b exp=0/0", c, we3, pend1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_contention();
    test_full_pop();
    test_r0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
